// File: rtl/cmd_fetcher.sv
// cmd_fetcher -- upstream stage of the command executor.
//
// Fetches 1..3 word commands from a synchronous instruction memory starting
// at pc, decodes the opcode into one-hot cmd_flags, packs the raw words into
// cmd_args and presents them with exe_flag until the executor answers with
// ready_flag. On retire, pc advances by the command length or by the jump
// offset when the executor asks for a jump.
//
// All outputs change on posedge only; the executor samples on negedge, so
// everything it sees is stable for a full cycle.
//
// Ports:
//   clk, rst_n           clock (posedge) / async active-low reset
//   run                  1 = keep fetching; 0 = stop at next command boundary
//   imem_rd_en/imem_addr one-cycle read strobe + word address to imem
//   imem_rdata           data for the address strobed on the previous posedge
//   exe_flag             command valid to executor
//   cmd_flags            {mov,add,cmp,jmp,je,ja}, one-hot or 0
//   cmd_args             {word2,word1,word0}, absent words are 0
//   ready_flag           executor finished the current command
//   jmp_flag             executor takes the jump (qualified by ready_flag)
//   new_exe_addr_offset  two's-complement jump offset added to pc
//   pc                   address of current / next command
//   halted               HALT executed or error hit (terminal)
//   illegal_op           sticky: bad opcode or fetch beyond IMEM_DEPTH
//   retired_cnt          number of commands accepted by the executor
module cmd_fetcher #(
   parameter int                      address_size = 32,
   parameter int                      word_size    = 32,
   parameter int                      IMEM_DEPTH   = 256,
   parameter logic [address_size-1:0] RESET_PC     = '0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      run,
   output logic                      imem_rd_en,
   output logic [address_size-1:0]   imem_addr,
   input  logic [word_size-1:0]      imem_rdata,
   output logic                      exe_flag,
   output logic [5:0]                cmd_flags,
   output logic [3*word_size-1:0]    cmd_args,
   input  logic                      ready_flag,
   input  logic                      jmp_flag,
   input  logic [address_size-1:0]   new_exe_addr_offset,
   output logic [address_size-1:0]   pc,
   output logic                      halted,
   output logic                      illegal_op,
   output logic [31:0]               retired_cnt
);

   localparam int AW = address_size;
   localparam int WW = word_size;

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_CAPT, S_ISSUE, S_WAIT, S_HALT, S_ERR
   } state_t;

   typedef struct packed {
      logic       legal;
      logic       halt;
      logic [1:0] len;
      logic [5:0] flags;
   } dec_t;

   function automatic dec_t decode(input logic [7:0] op);
      dec_t d;
      d.legal = 1'b1;
      d.halt  = 1'b0;
      d.len   = 2'd1;
      d.flags = 6'b000000;
      case (op)
         8'h00: d.halt = 1'b1;
         8'h01: begin d.len = 2'd3; d.flags = 6'b100000; end
         8'h02: d.flags = 6'b010000;
         8'h03: d.flags = 6'b001000;
         8'h04: begin d.len = 2'd2; d.flags = 6'b000100; end
         8'h05: begin d.len = 2'd2; d.flags = 6'b000010; end
         8'h06: begin d.len = 2'd2; d.flags = 6'b000001; end
         default: d.legal = 1'b0;
      endcase
      return d;
   endfunction

   state_t          state;
   logic [1:0]      idx;        // word of the command being fetched
   logic [1:0]      cmd_len;
   logic [5:0]      op_flags;
   logic [WW-1:0]   w0, w1;     // word2 never needs buffering, it goes straight out
   logic            req_oob;    // address latched for REQ is beyond imem

   dec_t            dec;
   logic            last_word;
   logic            go_req;
   logic            req_oob_c;
   logic [AW-1:0]   req_addr;
   logic [AW-1:0]   next_cmd_pc;
   logic [5:0]      flags_next;
   logic [3*WW-1:0] args_next;

   always_comb begin
      dec         = decode(imem_rdata[7:0]);
      // truncating add: pc wraps, negative offsets jump backwards
      next_cmd_pc = jmp_flag ? pc + new_exe_addr_offset : pc + AW'(cmd_len);
      // imem_rdata holds the final word of the command this cycle
      last_word   = (idx == 2'd0) ? (dec.len == 2'd1) : (idx == cmd_len - 2'd1);
      flags_next  = (idx == 2'd0) ? dec.flags : op_flags;
      args_next   = '0;
      case (idx)
         2'd0:    args_next = {{(2*WW){1'b0}}, imem_rdata};
         2'd1:    args_next = {{WW{1'b0}}, imem_rdata, w0};
         default: args_next = {imem_rdata, w1, w0};
      endcase
      // The read strobe is registered on the edge that enters REQ, so the
      // memory samples it at the end of REQ and the word is on imem_rdata
      // during CAPT: two cycles per word.
      go_req   = 1'b0;
      req_addr = pc;
      case (state)
         S_IDLE: go_req = run;
         S_CAPT: begin
            go_req   = !last_word;
            req_addr = pc + AW'(idx) + AW'(1);
         end
         S_WAIT: begin
            go_req   = ready_flag && run;
            req_addr = next_cmd_pc;
         end
         default: ;
      endcase
      req_oob_c = (req_addr >= AW'(IMEM_DEPTH));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         pc          <= RESET_PC;
         idx         <= '0;
         cmd_len     <= '0;
         op_flags    <= '0;
         w0          <= '0;
         w1          <= '0;
         req_oob     <= 1'b0;
         imem_rd_en  <= 1'b0;
         imem_addr   <= '0;
         exe_flag    <= 1'b0;
         cmd_flags   <= '0;
         cmd_args    <= '0;
         halted      <= 1'b0;
         illegal_op  <= 1'b0;
         retired_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: if (run) begin
               idx   <= '0;
               state <= S_REQ;
            end
            S_REQ: begin
               // strobe is never raised for an out-of-range address
               imem_rd_en <= 1'b0;
               if (req_oob) begin
                  halted     <= 1'b1;
                  illegal_op <= 1'b1;
                  state      <= S_ERR;
               end else begin
                  state <= S_CAPT;
               end
            end
            S_CAPT: begin
               if (idx == 2'd0) begin
                  w0       <= imem_rdata;
                  w1       <= '0;
                  cmd_len  <= dec.len;
                  op_flags <= dec.flags;
               end else if (idx == 2'd1) begin
                  w1 <= imem_rdata;
               end
               if (idx == 2'd0 && dec.halt) begin
                  halted <= 1'b1;
                  state  <= S_HALT;
               end else if (idx == 2'd0 && !dec.legal) begin
                  halted     <= 1'b1;
                  illegal_op <= 1'b1;
                  state      <= S_ERR;
               end else if (last_word) begin
                  exe_flag  <= 1'b1;
                  cmd_flags <= flags_next;
                  cmd_args  <= args_next;
                  state     <= S_ISSUE;
               end else begin
                  idx   <= idx + 2'd1;
                  state <= S_REQ;
               end
            end
            // command already on the outputs; one settle cycle before
            // ready_flag is honoured
            S_ISSUE: state <= S_WAIT;
            S_WAIT: if (ready_flag) begin
               // flags drop with exe_flag so executor write-enables keyed
               // off cmd_flags cannot fire twice
               exe_flag    <= 1'b0;
               cmd_flags   <= '0;
               cmd_args    <= '0;
               retired_cnt <= retired_cnt + 32'd1;
               pc          <= next_cmd_pc;
               idx         <= '0;
               state       <= run ? S_REQ : S_IDLE;
            end
            default: ;  // S_HALT / S_ERR: terminal until reset
         endcase
         if (go_req) begin
            imem_rd_en <= !req_oob_c;
            imem_addr  <= req_addr;
            req_oob    <= req_oob_c;
         end
      end
   end

endmodule
